// File: rtl/key_expand_seq_256_pkg.sv
// Shared definitions for the AES-256 key expansion sequencer:
// state encoding, sizes and GF(2^8) / S-box helpers.
package key_expand_seq_256_pkg;

  localparam int AES256_NWORDS = 60;
  localparam int AES256_NK     = 8;
  localparam logic [7:0] INV_EXP = 8'd254;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_EXPAND = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ x;
      else      p = p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (a^254, which maps 0 to 0) then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int n = 7; n >= 0; n--) begin
      r = gf_mul(r, r);
      if (INV_EXP[n]) r = gf_mul(r, a);
      else            r = r;
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/key_expand_seq_256_word_gen.sv
// Combinational AES-256 expansion step: w[i] from w[i-1] and w[i-8].
// Only valid for i >= 8; i mod 8 selects RotWord/SubWord/Rcon or SubWord alone.
module current_word_gen_256
  import key_expand_seq_256_pkg::*;
(
  input  logic [5:0]  i,
  input  logic [31:0] prev_word,
  input  logic [31:0] prev_period_word,
  output logic [31:0] word
);

  logic [7:0]  rcon_s;
  logic [31:0] temp_s;

  // Round constant for i = 8*j is x^(j-1)
  always_comb begin
    rcon_s = 8'h00;
    case (i[5:3])
      3'd1:    rcon_s = 8'h01;
      3'd2:    rcon_s = 8'h02;
      3'd3:    rcon_s = 8'h04;
      3'd4:    rcon_s = 8'h08;
      3'd5:    rcon_s = 8'h10;
      3'd6:    rcon_s = 8'h20;
      3'd7:    rcon_s = 8'h40;
      default: rcon_s = 8'h00;
    endcase
  end

  // Nonlinear transform of the previous word
  always_comb begin
    temp_s = prev_word;
    if (i[2:0] == 3'd0) begin
      temp_s = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon_s, 24'h000000};
    end else if (i[2:0] == 3'd4) begin
      temp_s = sub_word(prev_word);
    end else begin
      temp_s = prev_word;
    end
  end

  assign word = prev_period_word ^ temp_s;

endmodule

// File: rtl/key_expand_seq_256.sv
// AES-256 key expansion sequencer: streams w0..w59 into round-key memory,
// one word per cycle, and reports how many full round keys are stored.
module key_expand_seq_256
  import key_expand_seq_256_pkg::*;
#(
  parameter int NWORDS = AES256_NWORDS,
  parameter int NK     = AES256_NK
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [255:0] key,
  input  logic         abort,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic         we,
  output logic [5:0]   waddr,
  output logic [31:0]  wdata,
  output logic [3:0]   rk_avail
);

  state_t      state_r;
  logic [5:0]  i_r;
  logic [31:0] win_r [0:7];
  logic [31:0] gen_word_s;

  current_word_gen_256 u_word_gen (
    .i                (i_r),
    .prev_word        (win_r[7]),
    .prev_period_word (win_r[0]),
    .word             (gen_word_s)
  );

  // i_r is the index of the next word to emit; the state mirrors the visible outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= S_IDLE;
      i_r      <= 6'd0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      we       <= 1'b0;
      waddr    <= 6'd0;
      wdata    <= 32'h0000_0000;
      rk_avail <= 4'd0;
      for (int k = 0; k < 8; k++) win_r[k] <= 32'h0000_0000;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            for (int k = 0; k < 8; k++) win_r[k] <= key[255-32*k -: 32];
            state_r  <= S_LOAD;
            i_r      <= 6'd1;
            ready    <= 1'b0;
            busy     <= 1'b1;
            we       <= 1'b1;
            waddr    <= 6'd0;
            wdata    <= key[255:224];
            rk_avail <= 4'd0;
          end else begin
            state_r <= S_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            we      <= 1'b0;
          end
        end
        S_LOAD, S_EXPAND: begin
          if (abort) begin
            state_r  <= S_IDLE;
            i_r      <= 6'd0;
            ready    <= 1'b1;
            busy     <= 1'b0;
            we       <= 1'b0;
            rk_avail <= 4'd0;
          end else begin
            if (we && (waddr[1:0] == 2'b11)) rk_avail <= rk_avail + 4'd1;
            if (i_r == 6'(NWORDS)) begin
              state_r <= S_DONE;
              done    <= 1'b1;
              ready   <= 1'b1;
              busy    <= 1'b0;
              we      <= 1'b0;
            end else if (i_r < 6'(NK)) begin
              // Key words come straight from the unshifted window
              state_r <= S_LOAD;
              we      <= 1'b1;
              waddr   <= i_r;
              wdata   <= win_r[i_r[2:0]];
              i_r     <= i_r + 6'd1;
            end else begin
              state_r <= S_EXPAND;
              we      <= 1'b1;
              waddr   <= i_r;
              wdata   <= gen_word_s;
              i_r     <= i_r + 6'd1;
              for (int k = 0; k < 7; k++) win_r[k] <= win_r[k+1];
              win_r[7] <= gen_word_s;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          ready   <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
          we      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_expand_seq_256.sv
// Directed bench for key_expand_seq_256 using FIPS-197 and all-zero key vectors.
module tb_key_expand_seq_256;

  localparam logic [255:0] K1 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] K0 = 256'h0;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [255:0] key = 256'h0;
  logic         ready, busy, done, we;
  logic [5:0]   waddr;
  logic [31:0]  wdata;
  logic [3:0]   rk_avail;

  int n_checks = 0;
  int n_err = 0;
  logic [31:0] got [0:59];
  int nwr, done_at, first_we_at, addr_err;
  int n_done, n_we, hit;

  always #5 clk = ~clk;

  key_expand_seq_256 dut (
    .clk(clk), .resetn(resetn), .start(start), .key(key), .abort(abort),
    .ready(ready), .busy(busy), .done(done), .we(we), .waddr(waddr),
    .wdata(wdata), .rk_avail(rk_avail)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic kick(input logic [255:0] k);
    @(negedge clk);
    key = k;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called right after the accepting edge; records one expansion until done (bounded)
  task automatic capture(input bit chk_rk, input int s2_at, input logic [255:0] k2);
    nwr = 0; done_at = -1; first_we_at = -1; addr_err = 0;
    for (int j = 0; j < 60; j++) got[j] = 32'hdeadbeef;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check_val("busy_t1", 32'(busy), 32'd1);
        check_val("ready_t1", 32'(ready), 32'd0);
      end
      if (chk_rk) check_val($sformatf("rk_c%0d", c), 32'(rk_avail), 32'(nwr / 4));
      if (we) begin
        if (first_we_at < 0) first_we_at = c;
        if (waddr != 6'(nwr)) addr_err++;
        got[waddr] = wdata;
        nwr++;
      end
      if (c == s2_at) begin
        key = k2;
        start = 1'b1;
      end else if (c == s2_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        done_at = c;
        break;
      end
    end
  endtask

  task automatic check_timing(input string tag);
    check_val({tag, "_done_lat"}, 32'(done_at), 32'd61);
    check_val({tag, "_nwr"}, 32'(nwr), 32'd60);
    check_val({tag, "_addr_seq"}, 32'(addr_err), 32'd0);
    check_val({tag, "_first_we"}, 32'(first_we_at), 32'd1);
  endtask

  task automatic check_k1_stream(input string tag);
    logic [255:0] kk;
    kk = K1;
    for (int j = 0; j < 8; j++) check_val($sformatf("%s_w%0d", tag, j), got[j], kk[255-32*j -: 32]);
    check_val({tag, "_w8"},  got[8],  32'h9ba35411);
    check_val({tag, "_w9"},  got[9],  32'h8e6925af);
    check_val({tag, "_w10"}, got[10], 32'ha51a8b5f);
    check_val({tag, "_w11"}, got[11], 32'h2067fcde);
    check_val({tag, "_w56"}, got[56], 32'hfe4890d1);
    check_val({tag, "_w57"}, got[57], 32'he6188d0b);
    check_val({tag, "_w58"}, got[58], 32'h046df344);
    check_val({tag, "_w59"}, got[59], 32'h706c631e);
    check_timing(tag);
  endtask

  task automatic check_zero_stream(input string tag);
    for (int j = 0; j < 8; j++)   check_val($sformatf("%s_w%0d", tag, j), got[j], 32'h00000000);
    for (int j = 8; j < 12; j++)  check_val($sformatf("%s_w%0d", tag, j), got[j], 32'h62636363);
    for (int j = 12; j < 16; j++) check_val($sformatf("%s_w%0d", tag, j), got[j], 32'haafbfbfb);
    check_timing(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, 32'(ready), 32'd1);
    check_val({tag, "_busy"},  32'(busy),  32'd0);
    check_val({tag, "_done"},  32'(done),  32'd0);
    check_val({tag, "_we"},    32'(we),    32'd0);
    check_val({tag, "_waddr"}, 32'(waddr), 32'd0);
    check_val({tag, "_wdata"}, wdata,      32'd0);
    check_val({tag, "_rk"},    32'(rk_avail), 32'd0);
  endtask

  initial begin
    #2 resetn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;

    // FIPS-197 AES-256 vector
    kick(K1);
    capture(1'b0, -1, K0);
    check_k1_stream("k1");
    @(negedge clk);
    check_val("idle_ready", 32'(ready), 32'd1);
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_done", 32'(done), 32'd0);

    // All-zero key with per-cycle round-key progress
    kick(K0);
    capture(1'b1, -1, K0);
    check_zero_stream("zero");
    @(negedge clk);
    check_val("rk_hold_idle", 32'(rk_avail), 32'd15);

    // A second start during EXPAND must be ignored
    kick(K1);
    capture(1'b0, 20, K0);
    check_k1_stream("ign_start");
    n_done = 0; n_we = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) n_done++;
      if (we) n_we++;
    end
    check_val("ign_extra_done", 32'(n_done), 32'd0);
    check_val("ign_extra_we", 32'(n_we), 32'd0);

    // Abort while waddr 20 is on the write port
    kick(K1);
    hit = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (we && (waddr == 6'd20)) begin
        hit = 1;
        break;
      end
    end
    check_val("abort_reach20", 32'(hit), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check_val("abort_we", 32'(we), 32'd0);
    check_val("abort_ready", 32'(ready), 32'd1);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_rk", 32'(rk_avail), 32'd0);
    n_done = 0; n_we = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) n_done++;
      if (we) n_we++;
    end
    check_val("abort_no_done", 32'(n_done), 32'd0);
    check_val("abort_no_we", 32'(n_we), 32'd0);
    kick(K1);
    capture(1'b0, -1, K0);
    check_k1_stream("post_abort");

    // Asynchronous reset in the middle of EXPAND
    kick(K1);
    repeat (30) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    resetn = 1'b1;
    kick(K1);
    capture(1'b0, -1, K0);
    check_k1_stream("post_reset");

    // Back-to-back: start held during the done cycle
    kick(K1);
    capture(1'b0, -1, K0);
    check_k1_stream("b2b_first");
    key = K0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    capture(1'b1, -1, K0);
    check_zero_stream("b2b_second");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
